lsu_arbiter: RTL and testbench

LSU_ARBITER -- requirements
Module: lsu_arbiter

---
 rtl/lsu_arbiter.sv | 140 ++++++++++++++
 tb/tb_lsu_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/lsu_arbiter.sv
// Two-master arbiter in front of one shared LSU: IDLE -> ACCESS -> RESP, one transaction per 2 cycles at peak.
// Define LSU_ARB_FIXED_PRIO_EN for fixed m0 priority; default is burst-limited round-robin.
module lsu_arbiter #(
  parameter int          MAX_BURST = 4,
  parameter logic [31:0] RO_ADDR   = 32'h0000_0500
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic        m0_wren_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic        m1_wren_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic [31:0] lsu_addr_o,
  output logic [31:0] lsu_wdata_o,
  output logic        lsu_wren_o,
  input  logic [31:0] lsu_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic        owner;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        wren_q;
  logic        any_req, arb_en, win, ro_hit;

  assign any_req = m0_req_i | m1_req_i;
  assign arb_en  = any_req && (state == IDLE || state == RESP);
  assign ro_hit  = wren_q && (addr_q == RO_ADDR);

`ifdef LSU_ARB_FIXED_PRIO_EN
  always_comb begin
    win = owner;
    if (m0_req_i)      win = 1'b0;
    else if (m1_req_i) win = 1'b1;
  end
`else
  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  logic [3:0] burst_cnt;
  logic       keep;

  // burst_cnt==0 only right after reset, so the first tie goes to the non-owner (m0).
  assign keep = (burst_cnt != 4'd0) && (burst_cnt < MAX_B);

  always_comb begin
    win = owner;
    if (m0_req_i && !m1_req_i)      win = 1'b0;
    else if (!m0_req_i && m1_req_i) win = 1'b1;
    else if (m0_req_i && m1_req_i)  win = keep ? owner : ~owner;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      burst_cnt <= 4'd0;
    end else if (arb_en) begin
      if (win != owner)          burst_cnt <= 4'd1;
      else if (burst_cnt < MAX_B) burst_cnt <= burst_cnt + 4'd1;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner   <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      wren_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (arb_en) begin
        owner   <= win;
        addr_q  <= win ? m1_addr_i  : m0_addr_i;
        wdata_q <= win ? m1_wdata_i : m0_wdata_i;
        wren_q  <= win ? m1_wren_i  : m0_wren_i;
      end
      // For writes this captures the pre-write contents.
      if (state == ACCESS) rdata_q <= lsu_rdata_i;
    end
  end

  always_comb begin
    state_nxt   = state;
    m0_gnt_o    = 1'b0;
    m1_gnt_o    = 1'b0;
    m0_rvalid_o = 1'b0;
    m1_rvalid_o = 1'b0;
    m0_rdata_o  = '0;
    m1_rdata_o  = '0;
    m0_err_o    = 1'b0;
    m1_err_o    = 1'b0;
    lsu_addr_o  = '0;
    lsu_wdata_o = '0;
    lsu_wren_o  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        state_nxt   = RESP;
        m0_gnt_o    = ~owner;
        m1_gnt_o    = owner;
        lsu_addr_o  = addr_q;
        lsu_wdata_o = wdata_q;
        lsu_wren_o  = wren_q && !ro_hit;
      end
      RESP: begin
        state_nxt = any_req ? ACCESS : IDLE;
        if (owner) begin
          m1_rvalid_o = 1'b1;
          m1_rdata_o  = rdata_q;
          m1_err_o    = ro_hit;
        end else begin
          m0_rvalid_o = 1'b1;
          m0_rdata_o  = rdata_q;
          m0_err_o    = ro_hit;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter with a small word-addressed LSU memory model.
module tb_lsu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wren, m0_gnt, m0_rvalid, m0_err;
  logic        m1_req, m1_wren, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        lsu_wren;
  logic [31:0] mem [0:255];
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  lsu_arbiter #(.MAX_BURST(4), .RO_ADDR(32'h0000_0500)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_wren_i(m0_wren),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_wren_i(m1_wren),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
    .lsu_addr_o(lsu_addr), .lsu_wdata_o(lsu_wdata), .lsu_wren_o(lsu_wren),
    .lsu_rdata_i(lsu_rdata)
  );

  assign lsu_rdata = mem[lsu_addr[9:2]];
  always @(posedge clk) if (lsu_wren) mem[lsu_addr[9:2]] <= lsu_wdata;

  // {gnt0, gnt1, rvalid0, rvalid1, err0, err1, lsu_wren}
  function automatic logic [6:0] stat();
    return {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, lsu_wren};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic req, input logic [31:0] a,
                       input logic [31:0] d, input logic w);
    if (m == 0) begin
      m0_req = req; m0_addr = a; m0_wdata = d; m0_wren = w;
    end else begin
      m1_req = req; m1_addr = a; m1_wdata = d; m1_wren = w;
    end
  endtask

  task automatic txn(input int m, input logic [31:0] a, input logic [31:0] d, input logic w,
                     input logic [31:0] exp_rd, input logic exp_err, input logic exp_wren);
    logic [6:0] e;
    drive(m, 1'b1, a, d, w);
    step();
    e = '0; e[m == 0 ? 6 : 5] = 1'b1; e[0] = exp_wren;
    check("gnt_stat", 32'(stat()), 32'(e));
    check("lsu_addr", lsu_addr, a);
    check("lsu_wdata", lsu_wdata, d);
    drive(m, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    e = '0; e[m == 0 ? 4 : 3] = 1'b1; e[m == 0 ? 2 : 1] = exp_err;
    check("resp_stat", 32'(stat()), 32'(e));
    check("rdata", (m == 0) ? m0_rdata : m1_rdata, exp_rd);
    check("lsu_addr_resp", lsu_addr, 32'h0);
    step();
    check("idle_stat", 32'(stat()), 32'h0);
    check("idle_rdata", m0_rdata | m1_rdata, 32'h0);
  endtask

  initial begin
    logic [1:0] eg;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[0] = 32'h0000_1234;
    rst = 1'b1;
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (3) step();
    check("rst_stat", 32'(stat()), 32'h0);
    check("rst_lsu", lsu_addr | lsu_wdata | m0_rdata | m1_rdata, 32'h0);
    rst = 1'b0;
    step();

    txn(0, 32'h0000_0400, 32'h0, 1'b0, 32'h0000_1234, 1'b0, 1'b0);
    txn(1, 32'h0000_0490, 32'h0000_00AB, 1'b1, 32'hC0DE_0024, 1'b0, 1'b1);
    txn(0, 32'h0000_0500, 32'h0000_7777, 1'b1, 32'hC0DE_0040, 1'b1, 1'b0);
    txn(0, 32'h0000_0490, 32'h0, 1'b0, 32'h0000_00AB, 1'b0, 1'b0);
    txn(1, 32'h0000_0500, 32'h0, 1'b0, 32'hC0DE_0040, 1'b0, 1'b0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 1'b1, 32'h0000_0404, 32'h0, 1'b0);
    drive(1, 1'b1, 32'h0000_0408, 32'h0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step();
`ifdef LSU_ARB_FIXED_PRIO_EN
      eg = 2'b10;
`else
      eg = (((i / 4) % 2) == 0) ? 2'b10 : 2'b01;
`endif
      check($sformatf("burst_gnt%0d", i), 32'({m0_gnt, m1_gnt}), 32'(eg));
      step();
      check($sformatf("burst_rv%0d", i), 32'({m0_rvalid, m1_rvalid}), 32'(eg));
    end
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    step();
    check("burst_idle", 32'(stat()), 32'h0);

    drive(1, 1'b1, 32'h0000_04A0, 32'h0000_0055, 1'b1);
    step();
    check("rstw_gnt", 32'(stat()), 32'h21);
    rst = 1'b1;
    drive(1, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    check("rstw_stat", 32'(stat()), 32'h0);
    check("rstw_lsu", lsu_addr | lsu_wdata | m1_rdata, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("rstw_norv%0d", i), 32'(stat()), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
